// File: rtl/ofm_requant_pack.sv
// Buffers per-column conv sums, requantizes them through a shared 2-stage pipe
// and packs four int8 results per column into 32-bit OFM words.
module ofm_requant_pack #(
    parameter int COL        = 8,
    parameter int SUM_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              cfg_mult,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic [COL*SUM_WIDTH-1:0] sum,
    input  logic [COL-1:0]           sum_valid,
    input  logic                     flush,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic [31:0]              ofm_data,
    output logic [$clog2(COL)-1:0]   ofm_col,
    output logic [2:0]               ofm_bytes,
    output logic                     flush_done,
    output logic [COL-1:0]           ovf_err
);
    localparam int CW = $clog2(COL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = SUM_WIDTH + 17;
    localparam logic signed [PW-1:0] SAT_MAX = PW'(127);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-128);

    // Column FIFOs
    logic [SUM_WIDTH-1:0] fifo_mem [COL][FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr [COL];
    logic [AW-1:0]        rd_ptr [COL];
    logic [AW:0]          fifo_cnt [COL];
    logic [COL-1:0]       nonempty, full, push, pop_vec;

    // Arbiter and pipe
    logic                 en, pop;
    logic [CW-1:0]        gnt, rr_ptr;
    logic [SUM_WIDTH-1:0] pop_data;
    logic signed [PW-1:0] a_ext, b_ext, prod;
    logic                 s1_valid;
    logic signed [PW-1:0] s1_prod;
    logic [CW-1:0]        s1_col;
    logic signed [PW-1:0] rnd, rsum, shifted, relu_r;
    logic [7:0]           sat_byte;
    logic                 s2_valid;
    logic [7:0]           s2_byte;
    logic [CW-1:0]        s2_col;

    // Packer and flush
    logic [1:0]           pend_cnt [COL];
    logic [7:0]           pend_byte [COL][3];
    logic                 flush_pending, drained, part_any;
    logic [CW-1:0]        part_col;
    logic [31:0]          pad_word;

    // Output handshake: a word transfers on any rising edge where ofm_valid and
    // ofm_ready are both high; while ofm_valid && !ofm_ready the whole pipe
    // freezes and the output register holds data/col/bytes unchanged.
    assign en = !(ofm_valid && !ofm_ready);

    always_comb begin
        for (int c = 0; c < COL; c++) begin
            nonempty[c] = (fifo_cnt[c] != '0);
            full[c]     = (fifo_cnt[c] == (AW+1)'(FIFO_DEPTH));
        end
    end

    // Round-robin: first nonempty column at or after rr_ptr, wrapping.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < COL; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= COL) idx = idx - COL;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                gnt   = CW'(idx);
            end
        end
        pop     = en && found;
        pop_vec = '0;
        if (pop) pop_vec[gnt] = 1'b1;
    end

    always_comb begin
        for (int c = 0; c < COL; c++)
            push[c] = sum_valid[c] && (!full[c] || pop_vec[c]);
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < COL; c++)
            if (push[c]) fifo_mem[c][wr_ptr[c]] <= sum[c*SUM_WIDTH +: SUM_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COL; c++) begin
                wr_ptr[c]   <= '0;
                rd_ptr[c]   <= '0;
                fifo_cnt[c] <= '0;
            end
            ovf_err <= '0;
            rr_ptr  <= '0;
        end else begin
            for (int c = 0; c < COL; c++) begin
                if (push[c])    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop_vec[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                case ({push[c], pop_vec[c]})
                    2'b10:   fifo_cnt[c] <= fifo_cnt[c] + 1'b1;
                    2'b01:   fifo_cnt[c] <= fifo_cnt[c] - 1'b1;
                    default: fifo_cnt[c] <= fifo_cnt[c];
                endcase
                if (sum_valid[c] && full[c] && !pop_vec[c]) ovf_err[c] <= 1'b1;
            end
            if (pop) rr_ptr <= (gnt == CW'(COL-1)) ? '0 : gnt + 1'b1;
        end
    end

    // Signed sum times zero-extended multiplier; the true product fits in PW bits.
    assign pop_data = fifo_mem[gnt][rd_ptr[gnt]];
    assign a_ext    = {{17{pop_data[SUM_WIDTH-1]}}, pop_data};
    assign b_ext    = {{(SUM_WIDTH+1){1'b0}}, cfg_mult};
    assign prod     = a_ext * b_ext;

    always_comb begin
        rnd      = (cfg_shift == 5'd0) ? '0 : (PW'(1) << (cfg_shift - 5'd1));
        rsum     = s1_prod + rnd;
        shifted  = rsum >>> cfg_shift;
        relu_r   = (cfg_relu && shifted[PW-1]) ? '0 : shifted;
        if (relu_r > SAT_MAX)      sat_byte = 8'h7F;
        else if (relu_r < SAT_MIN) sat_byte = 8'h80;
        else                       sat_byte = relu_r[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_col   <= '0;
            s2_valid <= 1'b0;
            s2_byte  <= '0;
            s2_col   <= '0;
        end else if (en) begin
            s1_valid <= pop;
            if (pop) begin
                s1_prod <= prod;
                s1_col  <= gnt;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_byte <= sat_byte;
                s2_col  <= s1_col;
            end
        end
    end

    // Sums still arriving count as not drained so they land before the flush.
    assign drained = (nonempty == '0) && !s1_valid && !s2_valid && (sum_valid == '0);

    always_comb begin
        part_any = 1'b0;
        part_col = '0;
        for (int c = COL-1; c >= 0; c--) begin
            if (pend_cnt[c] != 2'd0) begin
                part_any = 1'b1;
                part_col = CW'(c);
            end
        end
        pad_word = '0;
        for (int l = 0; l < 3; l++)
            if (2'(l) < pend_cnt[part_col]) pad_word[l*8 +: 8] = pend_byte[part_col][l];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COL; c++) begin
                pend_cnt[c] <= '0;
                for (int l = 0; l < 3; l++) pend_byte[c][l] <= '0;
            end
            ofm_valid     <= 1'b0;
            ofm_data      <= '0;
            ofm_col       <= '0;
            ofm_bytes     <= '0;
            flush_done    <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (flush && !flush_pending) flush_pending <= 1'b1;
            if (en) begin
                ofm_valid <= 1'b0;
                if (s2_valid) begin
                    if (pend_cnt[s2_col] == 2'd3) begin
                        ofm_valid        <= 1'b1;
                        ofm_data         <= {s2_byte, pend_byte[s2_col][2],
                                             pend_byte[s2_col][1], pend_byte[s2_col][0]};
                        ofm_col          <= s2_col;
                        ofm_bytes        <= 3'd4;
                        pend_cnt[s2_col] <= 2'd0;
                    end else begin
                        pend_byte[s2_col][pend_cnt[s2_col]] <= s2_byte;
                        pend_cnt[s2_col] <= pend_cnt[s2_col] + 2'd1;
                    end
                end else if (flush_pending && drained) begin
                    if (part_any) begin
                        ofm_valid          <= 1'b1;
                        ofm_data           <= pad_word;
                        ofm_col            <= part_col;
                        ofm_bytes          <= {1'b0, pend_cnt[part_col]};
                        pend_cnt[part_col] <= 2'd0;
                    end else begin
                        flush_done    <= 1'b1;
                        flush_pending <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ofm_requant_pack.sv
// Directed bench for ofm_requant_pack: hand-computed words checked with
// immediate assertions, one linear stimulus sequence.
module tb_ofm_requant_pack;
    localparam int COL = 8;
    localparam int SW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       cfg_mult;
    logic [4:0]        cfg_shift;
    logic              cfg_relu;
    logic [COL*SW-1:0] sum;
    logic [COL-1:0]    sum_valid;
    logic              flush;
    logic              ofm_valid;
    logic              ofm_ready;
    logic [31:0]       ofm_data;
    logic [2:0]        ofm_col;
    logic [2:0]        ofm_bytes;
    logic              flush_done;
    logic [COL-1:0]    ovf_err;

    int checks = 0;
    int errors = 0;

    ofm_requant_pack #(.COL(COL), .SUM_WIDTH(SW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .sum(sum), .sum_valid(sum_valid), .flush(flush),
        .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_data(ofm_data),
        .ofm_col(ofm_col), .ofm_bytes(ofm_bytes), .flush_done(flush_done),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input int c, input int v);
        sum_valid          = '0;
        sum[c*SW +: SW]    = v;
        sum_valid[c]       = 1'b1;
        tick();
        sum_valid          = '0;
    endtask

    task automatic send4(input int c, input int v0, input int v1, input int v2, input int v3);
        send(c, v0);
        send(c, v1);
        send(c, v2);
        send(c, v3);
    endtask

    // Waits (bounded) for a word with ofm_ready high, checks it, then consumes it.
    task automatic wait_word(input string tag, input logic [31:0] d,
                             input logic [2:0] col, input logic [2:0] nb);
        int n;
        n = 0;
        while (!ofm_valid && n < 80) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'b0, ofm_valid}, 32'd1);
        chk({tag, "_data"},  ofm_data, d);
        chk({tag, "_col"},   {29'b0, ofm_col}, {29'b0, col});
        chk({tag, "_bytes"}, {29'b0, ofm_bytes}, {29'b0, nb});
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_mult  = 16'd1;
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        sum       = '0;
        sum_valid = '0;
        flush     = 1'b0;
        ofm_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_valid", {31'b0, ofm_valid}, 32'd0);
        chk("rst_data",  ofm_data, 32'd0);
        chk("rst_col",   {29'b0, ofm_col}, 32'd0);
        chk("rst_bytes", {29'b0, ofm_bytes}, 32'd0);
        chk("rst_fdone", {31'b0, flush_done}, 32'd0);
        chk("rst_ovf",   {24'b0, ovf_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic word with latency check: valid 3 edges after the 4th sum
        send(0, 1);
        send(0, 2);
        send(0, 3);
        send(0, 4);
        chk("lat_e0", {31'b0, ofm_valid}, 32'd0);
        tick();
        chk("lat_e1", {31'b0, ofm_valid}, 32'd0);
        tick();
        chk("lat_e2", {31'b0, ofm_valid}, 32'd0);
        tick();
        chk("lat_e3", {31'b0, ofm_valid}, 32'd1);
        wait_word("basic", 32'h04030201, 3'd0, 3'd4);
        chk("basic_drop", {31'b0, ofm_valid}, 32'd0);

        // Saturation, mult=1 shift=0
        send4(0, 300, -300, 5, -5);
        wait_word("sat", 32'hFB05807F, 3'd0, 3'd4);

        // ReLU
        cfg_relu = 1'b1;
        send4(0, -5, 100, -128, 127);
        wait_word("relu", 32'h7F006400, 3'd0, 3'd4);
        cfg_relu = 1'b0;

        // Rounding shift, mult=3 shift=2
        cfg_mult  = 16'd3;
        cfg_shift = 5'd2;
        send4(0, 5, -5, 6, -6);
        wait_word("rnd2", 32'hFC05FC04, 3'd0, 3'd4);

        // Half-up ties, mult=1 shift=1
        cfg_mult  = 16'd1;
        cfg_shift = 5'd1;
        send4(0, 3, -3, 1, -1);
        wait_word("tie", 32'h0001FF02, 3'd0, 3'd4);

        // Full-range unsigned multiplier, shift=16
        cfg_mult  = 16'hFFFF;
        cfg_shift = 5'd16;
        send4(0, 100, -100, 127, 200);
        wait_word("bigmul", 32'h7F7F9C64, 3'd0, 3'd4);
        cfg_mult  = 16'd1;
        cfg_shift = 5'd0;

        // Round-robin over all columns, pointer starting at 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < COL; c++) sum[c*SW +: SW] = c*16 + k;
            sum_valid = '1;
            tick();
        end
        sum_valid = '0;
        for (int c = 0; c < COL; c++) begin
            logic [7:0] b;
            b = 8'(c*16);
            wait_word($sformatf("rr%0d", c), {b + 8'd3, b + 8'd2, b + 8'd1, b},
                      3'(c), 3'd4);
        end
        chk("rr_ovf", {24'b0, ovf_err}, 32'd0);

        // Backpressure: output held stable while stalled
        ofm_ready = 1'b0;
        send4(1, 1, 2, 3, 4);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ofm_valid) begin
                chk("bp_hold_data",  ofm_data, 32'h04030201);
                chk("bp_hold_col",   {29'b0, ofm_col}, 32'd1);
                chk("bp_hold_bytes", {29'b0, ofm_bytes}, 32'd4);
            end
        end
        chk("bp_valid", {31'b0, ofm_valid}, 32'd1);
        ofm_ready = 1'b1;
        tick();
        chk("bp_accept", {31'b0, ofm_valid}, 32'd0);
        chk("bp_ovf", {24'b0, ovf_err}, 32'd0);

        // Flush with a partial word
        send(3, 7);
        send(3, 9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_word("flush3", 32'h00000907, 3'd3, 3'd2);
        chk("flush3_done", {31'b0, flush_done}, 32'd1);
        tick();
        chk("flush3_done_end", {31'b0, flush_done}, 32'd0);

        // Flush with nothing pending: done one cycle after drain
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fempty_d0", {31'b0, flush_done}, 32'd0);
        tick();
        chk("fempty_d1", {31'b0, flush_done}, 32'd1);
        chk("fempty_nov", {31'b0, ofm_valid}, 32'd0);
        tick();
        chk("fempty_d2", {31'b0, flush_done}, 32'd0);

        // Overflow: stall with col2 streaming 12 sums; 10 accepted, 2 dropped
        ofm_ready = 1'b0;
        for (int k = 0; k < 10; k++) send(2, k + 1);
        chk("ovf_before", {24'b0, ovf_err}, 32'd0);
        send(2, 11);
        chk("ovf_first_drop", {24'b0, ovf_err}, 32'h04);
        send(2, 12);
        chk("ovf_stall_data", ofm_data, 32'h04030201);
        ofm_ready = 1'b1;
        wait_word("ovf_w1", 32'h04030201, 3'd2, 3'd4);
        wait_word("ovf_w2", 32'h08070605, 3'd2, 3'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_word("ovf_tail", 32'h00000A09, 3'd2, 3'd2);
        chk("ovf_tail_done", {31'b0, flush_done}, 32'd1);
        chk("ovf_sticky", {24'b0, ovf_err}, 32'h04);

        // Reset mid-stream with a stalled word and a loaded pipe
        ofm_ready = 1'b0;
        for (int k = 0; k < 6; k++) send(5, k + 1);
        tick();
        chk("mid_valid_pre", {31'b0, ofm_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_valid", {31'b0, ofm_valid}, 32'd0);
        chk("mid_data",  ofm_data, 32'd0);
        chk("mid_col",   {29'b0, ofm_col}, 32'd0);
        chk("mid_bytes", {29'b0, ofm_bytes}, 32'd0);
        chk("mid_ovf",   {24'b0, ovf_err}, 32'd0);
        chk("mid_fdone", {31'b0, flush_done}, 32'd0);
        rst = 1'b0;
        ofm_ready = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("post_flush_d0", {31'b0, flush_done}, 32'd0);
        tick();
        chk("post_flush_d1", {31'b0, flush_done}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("post_quiet", {31'b0, ofm_valid}, 32'd0);
            tick();
        end
        send4(5, 33, 34, 35, 36);
        wait_word("post_word", 32'h24232221, 3'd5, 3'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ofm_requant_pack.md
# ofm_requant_pack

Downstream consumer of the 3x3 conv kernel's per-column partial-sum outputs. It buffers each column's `sum`/`sum_valid` stream in a small FIFO and arbitrates columns round-robin into a shared 2-stage requantizer (multiply, rounding shift, optional ReLU, int8 saturation). It then packs four int8 results per column into 32-bit OFM words and presents them on a valid/ready port toward the OFM write-back path. The conv kernel has no backpressure, so FIFO overflow is flagged rather than prevented.

## Interface
- `COL`, 8: number of PE-array columns (sum lanes).
- `SUM_WIDTH`, 32: signed width of each column sum.
- `FIFO_DEPTH`, 4: entries per column FIFO (power of two, ≥2).
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_mult` in 16: unsigned requant multiplier; stable while busy.
- `cfg_shift` in 5: arithmetic right shift, 0..31.
- `cfg_relu` in 1: 1 = clamp negative results to 0.
- `sum` in COL*SUM_WIDTH: column c at bits [c*SUM_WIDTH +: SUM_WIDTH], signed.
- `sum_valid` in COL: per-column qualifier, sampled every rising edge.
- `flush` in 1: one-cycle pulse; emit all partial words once drained.
- `ofm_valid` out 1: output word valid.
- `ofm_ready` in 1: downstream accepts when `ofm_valid && ofm_ready`.
- `ofm_data` out 32: packed int8s, first-arrived byte in [7:0].
- `ofm_col` out $clog2(COL): source column of `ofm_data`.
- `ofm_bytes` out 3: valid bytes in `ofm_data`, 1..4; unused upper bytes are 0.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `ovf_err` out COL: sticky per-column overflow flag.

## Operation
- Push: `sum_valid[c]` writes `sum[c]` to FIFO c. If the FIFO is full and is not popped in the same cycle, the sample is dropped and `ovf_err[c]` is set. The flag clears only on reset. If the FIFO is full and popped in the same cycle, the push is accepted.
- Arbiter: at most one pop per enabled cycle. It grants the lowest nonempty column ≥ pointer, wrapping. After a grant to c, pointer = (c+1) mod COL. The pointer resets to 0.
- S1 register: product = `sum` (signed) × `cfg_mult` (unsigned, zero-extended), full SUM_WIDTH+17 bits, plus column tag.
- S2 register:
  - shift = 0: r = p.
  - otherwise: r = (p + 2^(shift-1)) >>> shift (round half up).
  - If `cfg_relu` and r<0, then r = 0.
  - Saturate to [-128,127] and carry the tag.
- Packer: each column holds 0..3 pending bytes plus a count. A byte from S2 appends at lane = count. When the 4th byte arrives, the three pending bytes and the new byte load the output register directly (`ofm_bytes`=4) and the count clears.
- Global stall: enable = !(`ofm_valid` && !`ofm_ready`). While stalled, there are no pops and S1, S2 and the packers hold. FIFO pushes continue.
- Flush: `flush` sets flush_pending. Once all FIFOs, S1 and S2 are empty, each column with count>0 emits one zero-padded word in ascending column order with `ofm_bytes`=count, and its count clears. `flush_done` pulses in the cycle after the last such word is accepted, or one cycle after drain if there are no partial words. New sums arriving while pending are processed first and delay completion. A `flush` pulse while already pending is ignored.
- Reset (at any time, including mid-stream or mid-flush): FIFOs, pipe, packers, pointer, flush_pending and `ovf_err` clear. All outputs go to 0.

## Timing
- Uncontended latency: a sum sampled at edge E0 pops at E1 (into S1), reaches S2 at E2 and enters the packer/output register at E3. If it completes a word, `ofm_valid` is high from E3.
- There is no FIFO bypass; pop happens at earliest the edge after push.
- Throughput: 1 byte/cycle aggregate, 1 word per 4 bytes.
- `ofm_data`, `ofm_col` and `ofm_bytes` are held stable while `ofm_valid && !ofm_ready`.
- `ofm_valid` is registered. It drops the cycle after acceptance unless a new word loads on the same edge.
- `flush_done` and `ovf_err` are registered.

## Test plan
- Basic: mult=1, shift=0, relu=0; col0 sums 1,2,3,4 on consecutive cycles, `ofm_ready`=1 → one word 0x04030201, `ofm_col`=0, `ofm_bytes`=4, with `ofm_valid` 3 cycles after the 4th sum.
- Arithmetic, mult=1 shift=0: sum 300 → 0x7F; sum -300 → 0x80; with relu=1, sum -5 → 0x00. With mult=3, shift=2: sum 5 → 0x04; sum -5 → 0xFC (-4).
- Round-robin: all 8 columns valid for 4 cycles with sums c*16+k → 8 words in order col 0..7, each 0x(c*16+3)(c*16+2)(c*16+1)(c*16+0), with no `ovf_err`.
- Backpressure: `ofm_ready`=0 for 20 cycles while col1 streams 4 sums, then ready=1 → identical word, outputs held stable throughout, `ovf_err`=0.
- Overflow: ready=0, col2 valid for 12 consecutive cycles → `ovf_err[2]` set on the first dropped push. After ready=1, accepted byte count equals the number of non-dropped pushes. `ovf_err[2]` stays set until `rst`.
- Flush/reset:
  - col3 gets 2 sums (7,9), then `flush` → word 0x00000907, `ofm_bytes`=2, col 3, then `flush_done` pulse.
  - Asserting `rst` mid-stream → all outputs 0 next cycle and no stale words after release.
